// File: rtl/addr_seq_pkg.sv
// rtl/addr_seq_pkg.sv - shared state enum and default sizes for the address sequencer
package addr_seq_pkg;

  localparam int DEF_ADDR_SIZE  = 8;
  localparam int DEF_DEC_WIDTH  = 32;
  localparam int DEF_LOOP_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/addr_sequencer_if.sv
// rtl/addr_sequencer_if.sv - address beat handshake between sequencer and consumer
interface addr_sequencer_if #(
  parameter int ADDR_SIZE = addr_seq_pkg::DEF_ADDR_SIZE
);

  logic [ADDR_SIZE-1:0] addr;
  logic                 addr_valid;
  logic                 addr_ready;

  modport master (output addr, output addr_valid, input addr_ready);
  modport slave  (input addr, input addr_valid, output addr_ready);

endinterface

// File: rtl/addr_sequencer_dec_tick.sv
// rtl/addr_sequencer_dec_tick.sv - decimation counter counting 0..limit, frozen while a beat is pending
module dec_tick #(
  parameter int DEC_WIDTH = addr_seq_pkg::DEF_DEC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 freeze,
  input  logic [DEC_WIDTH-1:0] limit,
  output logic                 tick
);

  logic [DEC_WIDTH-1:0] cnt;
  logic                 at_limit;

  assign at_limit = (cnt == limit);
  assign tick     = ~clear & ~freeze & at_limit;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= at_limit ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/addr_sequencer.sv
// rtl/addr_sequencer.sv - decimated start..end address generator with valid/ready output
// Multi-pass looping and the wrap pulse exist only when ADDR_SEQ_LOOP_EN is defined.
module addr_sequencer
  import addr_seq_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int DEC_WIDTH  = DEF_DEC_WIDTH,
  parameter int LOOP_WIDTH = DEF_LOOP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_SIZE-1:0]  start_addr,
  input  logic [ADDR_SIZE-1:0]  end_addr,
  input  logic [DEC_WIDTH-1:0]  decimate,
  input  logic [LOOP_WIDTH-1:0] loops,
  addr_sequencer_if.master      bus,
  output logic                  wrap,
  output logic                  busy,
  output logic                  finish
);

  seq_state_e state_q, state_d;

  logic                 en_q;
  logic [ADDR_SIZE-1:0] start_q, start_d;
  logic [ADDR_SIZE-1:0] end_q, end_d;
  logic [ADDR_SIZE-1:0] nxt_q, nxt_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DEC_WIDTH-1:0] dec_q, dec_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 finish_q, finish_d;

  logic                 accept, at_end, more, last, restart, tick;
  logic [ADDR_SIZE-1:0] seq;

`ifdef ADDR_SEQ_LOOP_EN
  logic [LOOP_WIDTH-1:0] loop_q, loop_d;
  logic                  wrap_q, wrap_d;

  assign more = (loop_q != '0);
  assign wrap = wrap_q;
`else
  logic unused_loops;

  assign unused_loops = ^loops;
  assign more         = 1'b0;
  assign wrap         = 1'b0;
`endif

  assign accept  = valid_q & bus.addr_ready;
  assign at_end  = accept & (addr_q == end_q);
  assign last    = at_end & ~more;
  assign restart = at_end & more;
  // Once end_addr is accepted on a looping pass, the next emitted address is start again.
  assign seq     = restart ? start_q : nxt_q;

  dec_tick #(
    .DEC_WIDTH(DEC_WIDTH)
  ) u_dec_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear ((state_q != RUN) | ~en),
    .freeze(valid_q & ~bus.addr_ready),
    .limit (dec_q),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    end_d    = end_q;
    dec_d    = dec_q;
    nxt_d    = nxt_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    finish_d = finish_q;
`ifdef ADDR_SEQ_LOOP_EN
    loop_d   = loop_q;
    wrap_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en && !en_q) begin
          state_d  = RUN;
          start_d  = start_addr;
          end_d    = end_addr;
          dec_d    = decimate;
          nxt_d    = start_addr;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          finish_d = 1'b0;
`ifdef ADDR_SEQ_LOOP_EN
          loop_d   = loops;
`endif
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
`ifdef ADDR_SEQ_LOOP_EN
          loop_d  = '0;
`endif
        end else if (last) begin
          state_d  = DONE;
          valid_d  = 1'b0;
          busy_d   = 1'b0;
          finish_d = 1'b1;
        end else begin
          if (accept) begin
            valid_d = 1'b0;
          end
`ifdef ADDR_SEQ_LOOP_EN
          if (restart) begin
            wrap_d = 1'b1;
            loop_d = loop_q - 1'b1;
          end
`endif
          nxt_d = seq;
          if (tick) begin
            addr_d  = seq;
            valid_d = 1'b1;
            nxt_d   = seq + 1'b1;
          end
        end
      end
      DONE: begin
        if (!en) begin
          state_d  = IDLE;
          finish_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        finish_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      dec_q    <= '0;
      nxt_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
`ifdef ADDR_SEQ_LOOP_EN
      loop_q   <= '0;
      wrap_q   <= 1'b0;
`endif
    end else begin
      en_q     <= en;
      start_q  <= start_d;
      end_q    <= end_d;
      dec_q    <= dec_d;
      nxt_q    <= nxt_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
`ifdef ADDR_SEQ_LOOP_EN
      loop_q   <= loop_d;
      wrap_q   <= wrap_d;
`endif
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
  assign busy           = busy_q;
  assign finish         = finish_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// tb/tb_addr_sequencer.sv - directed self-checking bench for addr_sequencer
module tb_addr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  start_addr;
  logic [7:0]  end_addr;
  logic [31:0] decimate;
  logic [15:0] loops;
  logic        wrap;
  logic        busy;
  logic        finish;

  int errors = 0;
  int checks = 0;

  int beat_addr [64];
  int beat_cyc  [64];
  int nbeats;
  int nwraps;
  int done_cyc;
  bit timed_out;

  always #5 clk = ~clk;

  addr_sequencer_if #(.ADDR_SIZE(8)) bus ();

  addr_sequencer #(
    .ADDR_SIZE (8),
    .DEC_WIDTH (32),
    .LOOP_WIDTH(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .decimate  (decimate),
    .loops     (loops),
    .bus       (bus),
    .wrap      (wrap),
    .busy      (busy),
    .finish    (finish)
  );

  // Arms a run: en low for one edge, then high so the following edge is the RUN entry.
  task automatic go(input logic [7:0] s, input logic [7:0] e, input logic [31:0] d, input logic [15:0] l);
    start_addr = s;
    end_addr   = e;
    decimate   = d;
    loops      = l;
    en         = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  // Cycle c=1 is the first cycle after the RUN-entry edge; records accepted beats until finish.
  task automatic collect(input int budget);
    nbeats    = 0;
    nwraps    = 0;
    done_cyc  = -1;
    timed_out = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (wrap) nwraps++;
      if (finish) begin
        done_cyc  = c;
        timed_out = 1'b0;
        break;
      end
      if (bus.addr_valid && bus.addr_ready && nbeats < 64) begin
        beat_addr[nbeats] = int'(bus.addr);
        beat_cyc[nbeats]  = c;
        nbeats++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b1;
    bus.addr_ready = 1'b1;
    start_addr = 8'd7;
    end_addr = 8'd9;
    decimate = 32'd0;
    loops = 16'd0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.addr_valid); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", finish); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    checks++; if (bus.addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.addr); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    go(8'd2, 8'd5, 32'd0, 16'd0);
    collect(30);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b expected 0", timed_out); end
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_addr[i] !== 2 + i) begin errors++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, beat_addr[i], 2 + i); end
      checks++; if (beat_cyc[i] !== 2 + i) begin errors++; $display("FAIL basic_cycle[%0d]: got %0d expected %0d", i, beat_cyc[i], 2 + i); end
    end
    checks++; if (done_cyc !== 6) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 6", done_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_done_busy: got %b expected 0", busy); end
    checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL basic_done_valid: got %b expected 0", bus.addr_valid); end
    repeat (3) @(negedge clk);
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL done_persists: got %b expected 1", finish); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL done_to_idle_finish: got %b expected 0", finish); end
  endtask

  task automatic test_decimate;
    go(8'd0, 8'd1, 32'd3, 16'd0);
    collect(60);
    checks++; if (nbeats !== 2) begin errors++; $display("FAIL dec_count: got %0d expected 2", nbeats); end
    checks++; if (beat_cyc[0] !== 5) begin errors++; $display("FAIL dec_first_cycle: got %0d expected 5", beat_cyc[0]); end
    checks++; if (beat_cyc[1] !== 9) begin errors++; $display("FAIL dec_second_cycle: got %0d expected 9", beat_cyc[1]); end
    checks++; if (beat_addr[1] !== 1) begin errors++; $display("FAIL dec_second_addr: got %0d expected 1", beat_addr[1]); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL dec_done_cycle: got %0d expected 10", done_cyc); end
  endtask

  task automatic test_addr_wrap;
    int exp_a [4];
    exp_a = '{254, 255, 0, 1};
    go(8'd254, 8'd1, 32'd0, 16'd0);
    collect(30);
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL awrap_count: got %0d expected 4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_addr[i] !== exp_a[i]) begin errors++; $display("FAIL awrap_addr[%0d]: got %0d expected %0d", i, beat_addr[i], exp_a[i]); end
    end
    checks++; if (done_cyc !== 6) begin errors++; $display("FAIL awrap_done_cycle: got %0d expected 6", done_cyc); end
  endtask

  task automatic test_backpressure;
    int held = 0;
    int hold_first = -1;
    int hold_last = -1;
    int cyc3 = -1;
    int cyc4 = -1;
    int got_done = 0;
    go(8'd1, 8'd5, 32'd2, 16'd0);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (finish) begin
        got_done = c;
        break;
      end
      if (bus.addr_valid && bus.addr == 8'd3 && held < 5) begin
        bus.addr_ready = 1'b0;
        held++;
        if (hold_first < 0) hold_first = c;
        hold_last = c;
      end else begin
        bus.addr_ready = 1'b1;
      end
      if (bus.addr_valid && bus.addr_ready) begin
        if (bus.addr == 8'd3) cyc3 = c;
        if (bus.addr == 8'd4) cyc4 = c;
      end
    end
    bus.addr_ready = 1'b1;
    checks++; if (held !== 5) begin errors++; $display("FAIL bp_held: got %0d expected 5", held); end
    checks++; if (hold_first !== 10) begin errors++; $display("FAIL bp_hold_first: got %0d expected 10", hold_first); end
    checks++; if (hold_last !== 14) begin errors++; $display("FAIL bp_hold_last: got %0d expected 14", hold_last); end
    checks++; if (cyc3 !== 15) begin errors++; $display("FAIL bp_accept3: got %0d expected 15", cyc3); end
    checks++; if (cyc4 !== 18) begin errors++; $display("FAIL bp_beat4: got %0d expected 18", cyc4); end
    checks++; if (got_done !== 22) begin errors++; $display("FAIL bp_done_cycle: got %0d expected 22", got_done); end
  endtask

  task automatic test_loops;
    int exp_n;
    int exp_w;
`ifdef ADDR_SEQ_LOOP_EN
    exp_n = 9;
    exp_w = 2;
`else
    exp_n = 3;
    exp_w = 0;
`endif
    go(8'd0, 8'd2, 32'd0, 16'd2);
    collect(60);
    checks++; if (nbeats !== exp_n) begin errors++; $display("FAIL loops_count: got %0d expected %0d", nbeats, exp_n); end
    checks++; if (nwraps !== exp_w) begin errors++; $display("FAIL loops_wraps: got %0d expected %0d", nwraps, exp_w); end
    for (int i = 0; i < exp_n; i++) begin
      checks++; if (beat_addr[i] !== i % 3) begin errors++; $display("FAIL loops_addr[%0d]: got %0d expected %0d", i, beat_addr[i], i % 3); end
      checks++; if (beat_cyc[i] !== 2 + i) begin errors++; $display("FAIL loops_cycle[%0d]: got %0d expected %0d", i, beat_cyc[i], 2 + i); end
    end
    checks++; if (done_cyc !== 2 + exp_n) begin errors++; $display("FAIL loops_done_cycle: got %0d expected %0d", done_cyc, 2 + exp_n); end
  endtask

  task automatic test_abort;
    go(8'd10, 8'd20, 32'd0, 16'd0);
    repeat (3) @(negedge clk);
    checks++; if (bus.addr !== 8'd11) begin errors++; $display("FAIL abort_pre_addr: got %0d expected 11", bus.addr); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL abort_en_valid: got %b expected 0", bus.addr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_en_busy: got %b expected 0", busy); end
    en = 1'b1;
    collect(40);
    checks++; if (beat_addr[0] !== 10) begin errors++; $display("FAIL abort_en_restart_addr: got %0d expected 10", beat_addr[0]); end
    checks++; if (beat_cyc[0] !== 2) begin errors++; $display("FAIL abort_en_restart_cycle: got %0d expected 2", beat_cyc[0]); end
    checks++; if (nbeats !== 11) begin errors++; $display("FAIL abort_en_restart_count: got %0d expected 11", nbeats); end

    go(8'd10, 8'd20, 32'd0, 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL abort_rst_valid: got %b expected 0", bus.addr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_rst_busy: got %b expected 0", busy); end
    checks++; if (bus.addr !== 8'd0) begin errors++; $display("FAIL abort_rst_addr: got %0d expected 0", bus.addr); end
    rst_n = 1'b1;
    en = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_rst_stays_idle: got %b expected 0", busy); end
    en = 1'b1;
    collect(40);
    checks++; if (beat_addr[0] !== 10) begin errors++; $display("FAIL abort_rst_restart_addr: got %0d expected 10", beat_addr[0]); end
    checks++; if (beat_cyc[0] !== 2) begin errors++; $display("FAIL abort_rst_restart_cycle: got %0d expected 2", beat_cyc[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decimate();
    test_addr_wrap();
    test_backpressure();
    test_loops();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
